// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared widths, polarities, constants and FSM encodings for the fetch unit
package ifu_fetch_pkg;

    localparam int INST_BUS_W      = 32;
    localparam int INST_ADDR_BUS_W = 32;

    localparam logic RST_ENABLE  = 1'b1;
    localparam logic CHIP_ENABLE = 1'b1;
    localparam logic BRANCH      = 1'b1;

    localparam logic [INST_ADDR_BUS_W-1:0] DEF_RESET_PC = 32'h8000_0000;
    localparam logic [INST_BUS_W-1:0]      DEF_NOP_INST = 32'h0000_0013;
    localparam logic [7:0]                 DEF_TIMEOUT  = 8'd255;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_DROP = 3'd4;

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - instruction-memory port and downstream instruction stream interfaces
interface ifu_mem_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [INST_W-1:0] rdata;
    logic              err;

    modport master (output req, addr, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

interface ifu_inst_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              valid;
    logic              ready;
    logic [INST_W-1:0] data;
    logic [ADDR_W-1:0] pc;
    logic              err;

    modport master (output valid, data, pc, err, input ready);
    modport slave  (input valid, data, pc, err, output ready);
endinterface

// File: rtl/ifu_timeout_cnt.sv
// rtl/ifu_timeout_cnt.sv - clearable saturating response-timeout counter with a limit-hit flag
module ifu_timeout_cnt #(
    parameter int           W     = 8,
    parameter logic [W-1:0] LIMIT = {W{1'b1}}
)(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [W-1:0] cnt_q;

    // Clear wins over enable; the count parks at LIMIT instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hit = (cnt_q == LIMIT);

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-outstanding instruction fetch between PC generator, instruction memory and decode
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000,
    parameter logic [7:0]        TIMEOUT  = 8'd255,
    parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i_ifu,
    input  logic [ADDR_W-1:0] pc_i_ifu,
    input  logic              flush_i_ifu,
    output logic              stall_o_ifu,
    ifu_mem_if.master         mem,
    ifu_inst_if.master        inst
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              err_q, err_d;
    logic              cnt_clr, cnt_en, cnt_hit;
    logic              fetch_en, flush;

    assign fetch_en = (ce_i_ifu == CHIP_ENABLE);
    assign flush    = (flush_i_ifu == BRANCH);

    ifu_timeout_cnt #(
        .W     (8),
        .LIMIT (TIMEOUT)
    ) u_timeout_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .hit (cnt_hit)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        err_d   = err_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fetch_en) begin
                    addr_d  = pc_i_ifu;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // A granted request is in flight even when flushed, so its response must be drained.
                if (mem.gnt) begin
                    cnt_clr = 1'b1;
                    state_d = flush ? S_DROP : S_WAIT;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_en = 1'b1;
                if (flush) begin
                    state_d = mem.rvalid ? S_IDLE : S_DROP;
                end else if (mem.rvalid) begin
                    inst_d  = mem.err ? NOP_INST : mem.rdata;
                    err_d   = mem.err;
                    pc_d    = addr_q;
                    state_d = S_OUT;
                end else if (cnt_hit) begin
                    inst_d  = NOP_INST;
                    err_d   = 1'b1;
                    pc_d    = addr_q;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (inst.ready) begin
                    if (fetch_en) begin
                        addr_d  = pc_i_ifu;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                cnt_en = 1'b1;
                if (mem.rvalid || cnt_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q <= S_IDLE;
            addr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    // The address bus is driven only while requesting so it reads as zero out of reset.
    assign mem.req    = (state_q == S_REQ);
    assign mem.addr   = (state_q == S_REQ) ? addr_q : '0;

    assign inst.valid = (state_q == S_OUT);
    assign inst.data  = inst_q;
    assign inst.pc    = pc_q;
    assign inst.err   = err_q;

    assign stall_o_ifu = (state_q != S_IDLE) && !((state_q == S_OUT) && inst.ready);

endmodule
